// File: rtl/imm_ext_pipe_if.sv
// rtl/imm_ext_pipe_if.sv - immediate extender handshake bundle
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  imm;
    logic [1:0]       extop;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] extout;

    // producer/consumer side
    modport master (
        output in_valid, imm, extop, out_ready,
        input  in_ready, out_valid, extout
    );

    // extender side
    modport slave (
        input  in_valid, imm, extop, out_ready,
        output in_ready, out_valid, extout
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered immediate extender with main/skid output stage
module imm_ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    imm_ext_pipe_if.slave bus,
    output logic [15:0] xfer_cnt
);
    logic             m_valid_q, m_valid_d;
    logic [OUT_W-1:0] m_data_q,  m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [OUT_W-1:0] s_data_q,  s_data_d;
    logic [15:0]      cnt_q,     cnt_d;
    logic [OUT_W-1:0] ext_res;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic             in_xfer;
    logic             out_xfer;

    // in_ready comes straight from the skid flag register, so out_ready never reaches it
    assign bus.in_ready  = ~s_valid_q;
    assign bus.out_valid = m_valid_q;
    assign bus.extout    = m_data_q;
    assign xfer_cnt      = cnt_q;

    assign in_xfer  = bus.in_valid & ~s_valid_q;
    assign out_xfer = m_valid_q & bus.out_ready;

    // extend the presented immediate according to extop
    always_comb begin
        zext = OUT_W'(bus.imm);
        sext = {{(OUT_W-IN_W){bus.imm[IN_W-1]}}, bus.imm};
        case (bus.extop)
            2'b00:   ext_res = zext;
            2'b01:   ext_res = sext;
            2'b10:   ext_res = zext << (OUT_W - IN_W);
            default: ext_res = sext << BR_SHIFT;
        endcase
    end

    // M/S steering: S always drains into M before any newer input can reach M
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        cnt_d     = cnt_q;
        if (!m_valid_q || bus.out_ready) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (in_xfer) begin
                m_valid_d = 1'b1;
                m_data_d  = ext_res;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            s_valid_d = 1'b1;
            s_data_d  = ext_res;
        end
        if (out_xfer && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // state registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - directed self-checking bench for imm_ext_pipe
module tb_imm_ext_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus0 ();
    imm_ext_pipe_if #(.IN_W(12), .OUT_W(24)) bus1 ();

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .xfer_cnt(cnt0)
    );
    imm_ext_pipe #(.IN_W(12), .OUT_W(24), .BR_SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .xfer_cnt(cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus0.in_valid = 1'b1; bus0.imm = 16'h1111; bus0.extop = 2'b00; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.imm = 12'h000;  bus1.extop = 2'b00; bus1.out_ready = 1'b1;
        step();
        step();
        n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus0.in_ready); end
        n_checks++; if (bus0.extout !== 32'h0) begin n_fail++; $display("FAIL reset_extout got %h want 0", bus0.extout); end
        n_checks++; if (cnt0 !== 16'h0) begin n_fail++; $display("FAIL reset_xfer_cnt got %0d want 0", cnt0); end
        reset = 1'b0;
        bus0.in_valid = 1'b0;
    endtask

    task automatic test_modes();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h00008004; exp_v[1] = 32'hFFFF8004;
        exp_v[2] = 32'h80040000; exp_v[3] = 32'hFFFE0010;
        bus0.out_ready = 1'b1;
        bus0.in_valid = 1'b1; bus0.imm = 16'h8004; bus0.extop = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (bus0.out_valid !== 1'b1 || bus0.extout !== exp_v[i]) begin
                n_fail++; $display("FAIL mode%0d_extout got v=%b %h want v=1 %h", i, bus0.out_valid, bus0.extout, exp_v[i]);
            end
            if (i < 3) bus0.extop = 2'(i + 1);
            else bus0.in_valid = 1'b0;
        end
        step();
        n_checks++; if (cnt0 !== 16'd4) begin n_fail++; $display("FAIL modes_xfer_cnt got %0d want 4", cnt0); end
        n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL modes_idle got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_positive();
        bus0.in_valid = 1'b1; bus0.imm = 16'h7FFF; bus0.extop = 2'b01;
        step();
        n_checks++; if (bus0.extout !== 32'h00007FFF) begin n_fail++; $display("FAIL pos_sext got %h want 00007fff", bus0.extout); end
        bus0.extop = 2'b11;
        step();
        n_checks++; if (bus0.extout !== 32'h0001FFFC) begin n_fail++; $display("FAIL pos_branch got %h want 0001fffc", bus0.extout); end
        bus0.in_valid = 1'b0;
        step();
        n_checks++; if (cnt0 !== 16'd6) begin n_fail++; $display("FAIL pos_xfer_cnt got %0d want 6", cnt0); end
    endtask

    task automatic test_backpressure();
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.imm = 16'h1234; bus0.extop = 2'b01;
        step();
        n_checks++; if (bus0.extout !== 32'h00001234 || bus0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_a_load got %h rdy=%b want 00001234 rdy=1", bus0.extout, bus0.in_ready);
        end
        bus0.imm = 16'hF000; bus0.extop = 2'b01;
        step();
        n_checks++; if (bus0.in_ready !== 1'b0 || bus0.extout !== 32'h00001234) begin
            n_fail++; $display("FAIL bp_b_skid got %h rdy=%b want 00001234 rdy=0", bus0.extout, bus0.in_ready);
        end
        bus0.imm = 16'h0003; bus0.extop = 2'b10;
        step();
        n_checks++; if (bus0.in_ready !== 1'b0 || bus0.extout !== 32'h00001234 || bus0.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_c_held got %h rdy=%b v=%b want 00001234 rdy=0 v=1", bus0.extout, bus0.in_ready, bus0.out_valid);
        end
        bus0.out_ready = 1'b1;
        step();
        n_checks++; if (bus0.extout !== 32'hFFFFF000 || bus0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_b got %h rdy=%b want fffff000 rdy=1", bus0.extout, bus0.in_ready);
        end
        step();
        n_checks++; if (bus0.extout !== 32'h00030000 || bus0.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_c got %h v=%b want 00030000 v=1", bus0.extout, bus0.out_valid);
        end
        bus0.in_valid = 1'b0;
        step();
        n_checks++; if (bus0.out_valid !== 1'b0 || cnt0 !== 16'd9) begin
            n_fail++; $display("FAIL bp_drain got v=%b cnt=%0d want v=0 cnt=9", bus0.out_valid, cnt0);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus0.out_ready = 1'b1;
        bus0.in_valid = 1'b1; bus0.imm = 16'd0; bus0.extop = 2'b00;
        for (int k = 0; k < 100; k++) begin
            step();
            n_checks++;
            if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b1 || bus0.extout !== 32'(k)) begin
                n_fail++; bad++;
                if (bad < 4) $display("FAIL b2b_%0d got v=%b rdy=%b %h want v=1 rdy=1 %h", k, bus0.out_valid, bus0.in_ready, bus0.extout, 32'(k));
            end
            if (k < 99) bus0.imm = 16'(k + 1);
            else bus0.in_valid = 1'b0;
        end
        step();
        n_checks++; if (cnt0 !== 16'd100) begin n_fail++; $display("FAIL b2b_xfer_cnt got %0d want 100", cnt0); end
    endtask

    task automatic test_reset_flush();
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.imm = 16'hAAAA; bus0.extop = 2'b00;
        step();
        bus0.imm = 16'hBBBB;
        step();
        n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got rdy=%b want 0", bus0.in_ready); end
        reset = 1'b1; bus0.out_ready = 1'b1; bus0.imm = 16'hCCCC;
        step();
        n_checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || cnt0 !== 16'd0 || bus0.extout !== 32'h0) begin
            n_fail++; $display("FAIL flush_reset got v=%b rdy=%b cnt=%0d %h want v=0 rdy=1 cnt=0 0", bus0.out_valid, bus0.in_ready, cnt0, bus0.extout);
        end
        reset = 1'b0; bus0.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (bus0.out_valid !== 1'b0 || cnt0 !== 16'd0) begin
                n_fail++; $display("FAIL flush_stale_%0d got v=%b cnt=%0d want v=0 cnt=0", k, bus0.out_valid, cnt0);
            end
        end
    endtask

    task automatic test_params();
        bus1.out_ready = 1'b1;
        bus1.in_valid = 1'b1; bus1.imm = 12'h800; bus1.extop = 2'b11;
        step();
        n_checks++; if (bus1.extout !== 24'hFFF000) begin n_fail++; $display("FAIL p12_branch got %h want fff000", bus1.extout); end
        bus1.imm = 12'hABC; bus1.extop = 2'b10;
        step();
        n_checks++; if (bus1.extout !== 24'hABC000) begin n_fail++; $display("FAIL p12_upper got %h want abc000", bus1.extout); end
        bus1.in_valid = 1'b0;
        step();
        n_checks++; if (cnt1 !== 16'd2 || bus1.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL p12_drain got cnt=%0d v=%b want cnt=2 v=0", cnt1, bus1.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_positive();
        test_backpressure();
        test_back_to_back();
        test_reset_flush();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
